// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-channel TDM transmitter.
// Optional build macro TDM_MUX4_FIXED_PRIO_EN is consumed by rr_arbiter4.
package tdm_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

    // Index reached by stepping 'step' channels forward from 'base', modulo CH_NUM.
    function automatic ch_idx_t ch_step(input ch_idx_t base, input int step);
        return ch_idx_t'((int'(base) + step) % CH_NUM);
    endfunction

endpackage

// File: rtl/tdm_mux4_if.sv
// Channel-side handshake plus the sel/data/enable lane driven towards a demux1to4.
// WIDTH must match the WIDTH of the tdm_mux4 instance it is bound to.
interface tdm_mux4_if
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) ();

    logic [CH_NUM*WIDTH-1:0] in_data;
    logic [CH_NUM-1:0]       in_valid;
    logic [CH_NUM-1:0]       in_ready;
    ch_idx_t                 sel;
    logic [WIDTH-1:0]        data;
    logic                    enable;

    modport master (
        output in_data, in_valid,
        input  in_ready, sel, data, enable
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sel, data, enable
    );

endinterface

// File: rtl/rr_arbiter4.sv
// Single-grant arbiter over four requests; round-robin by default,
// fixed priority (channel 3 highest) when TDM_MUX4_FIXED_PRIO_EN is defined.
module rr_arbiter4
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] req,
    output logic [CH_NUM-1:0] grant,
    output ch_idx_t           grant_idx
);

`ifdef TDM_MUX4_FIXED_PRIO_EN

    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst_n;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (req[i]) begin
                grant_idx = ch_idx_t'(i);
            end
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

`else

    ch_idx_t r_ptr;

    // Search ptr+1, ptr+2, ptr+3, ptr; the first pending request wins.
    always_comb begin
        logic    w_found;
        ch_idx_t w_idx;
        grant     = '0;
        grant_idx = r_ptr;
        w_found   = 1'b0;
        w_idx     = r_ptr;
        for (int off = 1; off <= CH_NUM; off++) begin
            w_idx = ch_step(r_ptr, off);
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                grant_idx = w_idx;
            end
        end
        if (w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ch_idx_t'(CH_NUM - 1);
        end else if (|req) begin
            r_ptr <= grant_idx;
        end
    end

`endif

endmodule

// File: rtl/tdm_mux4.sv
// Four-channel TDM transmitter: one-word buffer per channel, single-grant
// arbitration, registered sel/data/enable lane. See rr_arbiter4 for TDM_MUX4_FIXED_PRIO_EN.
module tdm_mux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    tdm_mux4_if.slave  bus
);

    logic [WIDTH-1:0]  r_hold [CH_NUM];
    logic [CH_NUM-1:0] r_full;
    ch_idx_t           r_sel;
    logic [WIDTH-1:0]  r_data;
    logic              r_enable;

    logic [CH_NUM-1:0] w_grant;
    logic [CH_NUM-1:0] w_ready;
    logic [CH_NUM-1:0] w_accept;
    ch_idx_t           w_grant_idx;
    logic [WIDTH-1:0]  w_in_word [CH_NUM];

    rr_arbiter4 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (r_full),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // A channel being served this cycle may refill on the same edge.
    assign w_ready      = ~r_full | w_grant;
    assign w_accept     = bus.in_valid & w_ready;
    assign bus.in_ready = w_ready;

    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign w_in_word[gi] = bus.in_data[gi*WIDTH +: WIDTH];

            always_ff @(posedge clk) begin
                if (w_accept[gi]) begin
                    r_hold[gi] <= w_in_word[gi];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full[gi] <= 1'b0;
                end else if (w_accept[gi]) begin
                    r_full[gi] <= 1'b1;
                end else if (w_grant[gi]) begin
                    r_full[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
            r_sel    <= '0;
            r_data   <= '0;
        end else if (|w_grant) begin
            r_enable <= 1'b1;
            r_sel    <= w_grant_idx;
            r_data   <= r_hold[w_grant_idx];
        end else begin
            r_enable <= 1'b0;
            r_data   <= '0;
        end
    end

    assign bus.sel    = r_sel;
    assign bus.data   = r_data;
    assign bus.enable = r_enable;

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4 (WIDTH=4); honours TDM_MUX4_FIXED_PRIO_EN when defined.
module tb_tdm_mux4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    tdm_mux4_if #(.WIDTH(4)) bus ();

    tdm_mux4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel words loaded by the "all four at once" vector 16'h3C5A.
    localparam logic [3:0] CH_DATA [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
`ifdef TDM_MUX4_FIXED_PRIO_EN
    localparam logic [1:0] ORDER [4]       = '{2'd3, 2'd2, 2'd1, 2'd0};
    localparam logic [3:0] READY_AFTER [4] = '{4'b1100, 4'b1110, 4'b1111, 4'b1111};
    localparam logic [3:0] READY_LOADED    = 4'b1000;
`else
    localparam logic [1:0] ORDER [4]       = '{2'd0, 2'd1, 2'd2, 2'd3};
    localparam logic [3:0] READY_AFTER [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1111};
    localparam logic [3:0] READY_LOADED    = 4'b0001;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 4'($urandom);
            bus.in_data  = 16'($urandom);
            tick();
            n_vec++;
            if ({bus.enable, bus.sel, bus.data, bus.in_ready} !== {1'b0, 2'b00, 4'h0, 4'hF}) begin
                n_err++;
                $display("FAIL reset_values: got en=%b sel=%b data=%h rdy=%b, want en=0 sel=00 data=0 rdy=1111",
                         bus.enable, bus.sel, bus.data, bus.in_ready);
            end
        end
        bus.in_valid = '0;
        rst_n = 1'b1;
        $display("test_reset: reset values checked");
    endtask

    task automatic test_single();
        do_reset();
        bus.in_valid = 4'b0100;
        bus.in_data  = 16'h0100;
        tick();
        bus.in_valid = '0;
        n_vec++;
        if (bus.enable !== 1'b0 || bus.in_ready[2] !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: got en=%b rdy2=%b, want en=0 rdy2=1", bus.enable, bus.in_ready[2]);
        end
        tick();
        n_vec++;
        if ({bus.enable, bus.sel, bus.data} !== {1'b1, 2'b10, 4'h1}) begin
            n_err++;
            $display("FAIL single_out: got en=%b sel=%b data=%h, want en=1 sel=10 data=1", bus.enable, bus.sel, bus.data);
        end
        tick();
        n_vec++;
        if ({bus.enable, bus.sel, bus.data} !== {1'b0, 2'b10, 4'h0}) begin
            n_err++;
            $display("FAIL single_idle: got en=%b sel=%b data=%h, want en=0 sel=10 data=0", bus.enable, bus.sel, bus.data);
        end
        $display("test_single: ch2 word forwarded once");
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.in_valid = 4'b1111;
        bus.in_data  = 16'h3C5A;
        tick();
        bus.in_valid = '0;
        n_vec++;
        if (bus.enable !== 1'b0 || bus.in_ready !== READY_LOADED) begin
            n_err++;
            $display("FAIL simul_loaded: got en=%b rdy=%b, want en=0 rdy=%b", bus.enable, bus.in_ready, READY_LOADED);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({bus.enable, bus.sel, bus.data, bus.in_ready} !==
                {1'b1, ORDER[k], CH_DATA[ORDER[k]], READY_AFTER[k]}) begin
                n_err++;
                $display("FAIL simul_slot%0d: got en=%b sel=%b data=%h rdy=%b, want en=1 sel=%b data=%h rdy=%b",
                         k, bus.enable, bus.sel, bus.data, bus.in_ready,
                         ORDER[k], CH_DATA[ORDER[k]], READY_AFTER[k]);
            end
        end
        tick();
        n_vec++;
        if (bus.enable !== 1'b0 || bus.data !== 4'h0) begin
            n_err++;
            $display("FAIL simul_drain: got en=%b data=%h, want en=0 data=0", bus.enable, bus.data);
        end
        $display("test_simultaneous: four channels served in rotation");
    endtask

    task automatic test_fairness();
        int cnt0;
        int cnt3;
        logic [1:0] exp_sel;
        cnt0 = 0;
        cnt3 = 0;
        do_reset();
        bus.in_valid = 4'b1001;
        bus.in_data  = 16'h9006;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
`ifdef TDM_MUX4_FIXED_PRIO_EN
            exp_sel = 2'd3;
            n_vec++;
            if (bus.in_ready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL fair_starve_rdy0 cycle %0d: got %b, want 0", c, bus.in_ready[0]);
            end
`else
            exp_sel = (c % 2 == 0) ? 2'd0 : 2'd3;
`endif
            n_vec++;
            if ({bus.enable, bus.sel, bus.data} !== {1'b1, exp_sel, (exp_sel == 2'd0) ? 4'h6 : 4'h9}) begin
                n_err++;
                $display("FAIL fair_cycle%0d: got en=%b sel=%b data=%h, want en=1 sel=%b",
                         c, bus.enable, bus.sel, bus.data, exp_sel);
            end
            if (bus.enable && bus.sel == 2'd0) cnt0++;
            if (bus.enable && bus.sel == 2'd3) cnt3++;
        end
        bus.in_valid = '0;
        n_vec++;
`ifdef TDM_MUX4_FIXED_PRIO_EN
        if (cnt0 != 0 || cnt3 != 8) begin
`else
        if (cnt0 != 4 || cnt3 != 4) begin
`endif
            n_err++;
            $display("FAIL fair_share: got ch0=%0d ch3=%0d grants in 8 cycles", cnt0, cnt3);
        end
        $display("test_fairness: ch0=%0d ch3=%0d grants", cnt0, cnt3);
    endtask

    task automatic test_streaming();
        logic [3:0] words [4];
        words = '{4'h7, 4'h0, 4'hE, 4'h1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i < 4) ? 4'b0010 : 4'b0000;
            bus.in_data  = (i < 4) ? {8'h00, words[i], 4'h0} : 16'h0;
            n_vec++;
            if (bus.in_ready[1] !== 1'b1) begin
                n_err++;
                $display("FAIL stream_rdy%0d: got %b, want 1", i, bus.in_ready[1]);
            end
            tick();
            if (i > 0) begin
                n_vec++;
                if ({bus.enable, bus.sel, bus.data} !== {1'b1, 2'b01, words[i-1]}) begin
                    n_err++;
                    $display("FAIL stream_word%0d: got en=%b sel=%b data=%h, want en=1 sel=01 data=%h",
                             i - 1, bus.enable, bus.sel, bus.data, words[i-1]);
                end
            end
        end
        tick();
        n_vec++;
        if (bus.enable !== 1'b0) begin
            n_err++;
            $display("FAIL stream_end: got en=%b, want 0", bus.enable);
        end
        $display("test_streaming: ch1 streamed 4 words");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.in_valid = 4'b1111;
        bus.in_data  = 16'h3C5A;
        tick();
        bus.in_valid = '0;
        tick();
        n_vec++;
        if ({bus.enable, bus.sel, bus.data} !== {1'b1, ORDER[0], CH_DATA[ORDER[0]]}) begin
            n_err++;
            $display("FAIL burst_first: got en=%b sel=%b data=%h, want en=1 sel=%b data=%h",
                     bus.enable, bus.sel, bus.data, ORDER[0], CH_DATA[ORDER[0]]);
        end
        #2;
        rst_n = 1'b0;
        bus.in_valid = 4'($urandom);
        bus.in_data  = 16'($urandom);
        #1;
        n_vec++;
        if ({bus.enable, bus.sel, bus.data, bus.in_ready} !== {1'b0, 2'b00, 4'h0, 4'hF}) begin
            n_err++;
            $display("FAIL burst_async_rst: got en=%b sel=%b data=%h rdy=%b, want en=0 sel=00 data=0 rdy=1111",
                     bus.enable, bus.sel, bus.data, bus.in_ready);
        end
        tick();
        bus.in_valid = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (bus.enable !== 1'b0 || bus.data !== 4'h0) begin
                n_err++;
                $display("FAIL burst_stale%0d: got en=%b data=%h, want en=0 data=0", i, bus.enable, bus.data);
            end
        end
        $display("test_reset_mid_burst: buffered words discarded");
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        tick();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_streaming();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_mux4.md
# tdm_mux4

Four-channel time-division multiplexer: the transmit end of the select-tagged 1-to-4 demux link. It buffers one word per input channel, arbitrates between pending channels, and drives the `sel`/`data`/`enable` triple that a `demux1to4` receiver consumes. One word leaves per clock, so four slow sources share a single serial lane.

## Interface
- `WIDTH`, default 1: data width per channel.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  4*WIDTH  channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  4  per-channel valid.
- `in_ready`  out  4  per-channel ready (combinational).
- `sel`  out  2  index of the channel driving `data`; registered.
- `data`  out  WIDTH  the forwarded word; registered.
- `enable`  out  1  high when `sel`/`data` carry a valid word; registered.

## Operation
- Each channel i has a one-entry holding register `hold_q[i]` and a flag `full_q[i]`.
- Input handshake: the word transfers at a rising edge where `in_valid[i] & in_ready[i]`.
- `in_ready[i] = ~full_q[i] | grant[i]`, so a channel served this cycle can refill on the same edge.
- Arbiter: round-robin over `full_q`.
  - Search starts at `ptr+1` mod 4, where `ptr` is the last granted index.
  - At most one grant per cycle; `ptr` updates only on a grant.
- On a grant to channel k at an edge:
  - `enable<=1`, `sel<=k`, `data<=hold_q[k]`.
  - `full_q[k]` clears, unless a refill is accepted on the same edge, in which case it stays set with the new word.
- No channel full: `enable<=0`, `data<=0`, `sel` holds its last value.
- The output has no backpressure; the receiver must sample every cycle that `enable` is high.
- Simultaneous requests: all four channels are served in rotation order, one per cycle; no channel is ever dropped or duplicated.

## Timing
- Reset (async assert, synchronous-to-`clk` release is the integrator's job):
  - `enable=0`, `sel=2'b00`, `data=0`.
  - `full_q=0`, `ptr=3` (channel 0 has first priority).
  - `in_ready=4'b1111`.
- Latency:
  - A word accepted at edge N appears on `sel`/`data`/`enable` after edge N+1 if its channel wins at N+1.
  - Worst case with all channels contending: after edge N+4.
- Throughput:
  - Aggregate: 1 word/cycle.
  - A single active channel streams 1 word/cycle with `in_ready` held high.
- Reset mid-operation: buffered words are discarded and outputs return to reset values immediately. After release, arbitration restarts at channel 0.
- `ptr` wrap-around: 3 to 0.

## Configuration
- `TDM_MUX4_FIXED_PRIO_EN`:
  - Defined: the arbiter is fixed-priority, channel 3 highest and channel 0 lowest. `ptr` is removed and starvation of lower channels is permitted.
  - Undefined (default): round-robin as above.

## Structure
- Package `tdm_pkg`: `CH_NUM=4`, `SEL_W=2`, typedef `ch_idx_t` (logic [SEL_W-1:0]).
- Sub-module `rr_arbiter4`:
  - Inputs: `clk`, `rst_n`, `req[3:0]`.
  - Outputs: one-hot `grant[3:0]`, `grant_idx`.
  - Owns `ptr` and the macro-selected priority scheme.
- Top level holds the holding registers, the ready logic and the output registers.

## Test plan
- Reset: drive `rst_n=0` with random inputs → `enable=0`, `sel=00`, `data=0`, `in_ready=1111`. Re-assert mid-burst → same values immediately; no stale word is emitted after release.
- Single word: ch2 `in_valid` for one cycle with data=1 → exactly one cycle of `enable=1`, `sel=10`, `data=1` one edge later, then `enable=0`.
- Simultaneous: ch0..3 valid for one cycle with data 1,0,1,1 → `sel` = 00,01,10,11 on four consecutive cycles with data 1,0,1,1, then `enable=0`. `in_ready` of waiting channels is low until each is served.
- Fairness: ch0 and ch3 valid continuously → `sel` alternates 00,11,00,11…; each channel gets exactly 50% of cycles. With `TDM_MUX4_FIXED_PRIO_EN` → `sel=11` every cycle and ch0 `in_ready` stays low.
- Streaming: ch1 valid for 4 consecutive cycles with data 1,0,0,1 → `in_ready[1]` stays 1 and `enable=1`, `sel=01` for 4 cycles with data 1,0,0,1.
- Loopback: output feeds a `demux1to4` → each channel's data appears only on its matching output bit.
